// File: rtl/param_tcounter.sv
// ---------------------------------------------------------------------------
// param_tcounter
//   Generic modulo-N up/down event/cycle counter. It supports a synchronous
//   load with clamping, wrap or saturate at the range ends, a combinational
//   terminal-count strobe and a sticky overflow flag.
//
// Parameters
//   WIDTH    : counter width in bits (>= 1)
//   MODULUS  : count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//   SATURATE : 0 = wrap at the range ends, 1 = hold at the range ends
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset (q=0, ovf=0)
//   T        in   count enable, one step per clock
//   up       in   direction, 1 = increment, 0 = decrement
//   load     in   synchronous load strobe (highest priority)
//   load_val in   value to load, clamped to MODULUS-1
//   clr_ovf  in   synchronous clear of ovf (loses to a same-edge set)
//   q        out  registered count
//   q_gray   out  registered Gray code of q (only with GRAY_OUT_EN)
//   tc       out  terminal-count strobe (combinational)
//   ovf      out  sticky overflow/underflow flag
//
// Optional feature macro: GRAY_OUT_EN adds the q_gray output and register.
// The Gray output is only single-bit-change across the wrap when
// MODULUS == 2**WIDTH.
// ---------------------------------------------------------------------------
module param_tcounter #(
   parameter int WIDTH    = 3,
   parameter int MODULUS  = 8,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             T,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] q,
`ifdef GRAY_OUT_EN
   output logic [WIDTH-1:0] q_gray,
`endif
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
   // With a full binary range, the natural +1/-1 rollover performs the wrap.
   // In that case the clamp is a no-op because every load_val is in range.
   localparam bit               POW2 = (longint'(MODULUS) == (longint'(1) << WIDTH));

   logic [WIDTH-1:0] r_q;
   logic             r_ovf;
   logic             w_at_max;
   logic             w_at_min;
   logic [WIDTH-1:0] w_load_clamped;
   logic [WIDTH-1:0] w_up_next;
   logic [WIDTH-1:0] w_dn_next;
   logic [WIDTH-1:0] w_q_next;

   assign w_at_max = (r_q == MAX);
   assign w_at_min = (r_q == '0);

   assign tc = T & ~load & ((up & w_at_max) | (~up & w_at_min));

   generate
      if (POW2) begin : g_load_full
         assign w_load_clamped = load_val;
      end else begin : g_load_clamp
         assign w_load_clamped = (load_val > MAX) ? MAX : load_val;
      end

      if (POW2 && !SATURATE) begin : g_step_binary
         assign w_up_next = r_q + 1'b1;
         assign w_dn_next = r_q - 1'b1;
      end else if (SATURATE) begin : g_step_sat
         assign w_up_next = w_at_max ? r_q : r_q + 1'b1;
         assign w_dn_next = w_at_min ? r_q : r_q - 1'b1;
      end else begin : g_step_wrap
         assign w_up_next = w_at_max ? '0  : r_q + 1'b1;
         assign w_dn_next = w_at_min ? MAX : r_q - 1'b1;
      end
   endgenerate

   // Update priority: load first, then count, otherwise hold.
   always_comb begin
      w_q_next = r_q;
      if (load)
         w_q_next = w_load_clamped;
      else if (T)
         w_q_next = up ? w_up_next : w_dn_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_q <= '0;
      else
         r_q <= w_q_next;
   end

   // A set caused by tc wins over a clear on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_ovf <= 1'b0;
      else if (tc)
         r_ovf <= 1'b1;
      else if (clr_ovf)
         r_ovf <= 1'b0;
   end

   assign q   = r_q;
   assign ovf = r_ovf;

`ifdef GRAY_OUT_EN
   logic [WIDTH-1:0] r_q_gray;

   // Encoded from the next count so it tracks q on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_q_gray <= '0;
      else
         r_q_gray <= w_q_next ^ (w_q_next >> 1);
   end

   assign q_gray = r_q_gray;
`endif

endmodule

// File: tb/tb_param_tcounter.sv
// ---------------------------------------------------------------------------
// tb_param_tcounter
//   Directed scoreboard bench. There are three counter instances:
//     d0: WIDTH=3 MODULUS=8 SATURATE=0
//     d1: WIDTH=3 MODULUS=6 SATURATE=0
//     d2: WIDTH=3 MODULUS=6 SATURATE=1
//   Each row drives one instance for one cycle. Each row also pushes the
//   hand-computed q/tc/ovf expected during that cycle. A monitor pops and
//   compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_param_tcounter;

   typedef struct {
      int         id;
      logic [2:0] q;
      logic       tc;
      logic       ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       t_i   [3];
   logic       up_i  [3];
   logic       ld_i  [3];
   logic [2:0] lv_i  [3];
   logic       clr_i [3];
   logic [2:0] q_o   [3];
   logic [2:0] g_o   [3];
   logic       tc_o  [3];
   logic       ovf_o [3];

   logic [2:0] gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                3'b110, 3'b111, 3'b101, 3'b100};

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   param_tcounter #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) u_d0 (
      .clk(clk), .rst(rst), .T(t_i[0]), .up(up_i[0]), .load(ld_i[0]),
      .load_val(lv_i[0]), .clr_ovf(clr_i[0]), .q(q_o[0]),
`ifdef GRAY_OUT_EN
      .q_gray(g_o[0]),
`endif
      .tc(tc_o[0]), .ovf(ovf_o[0]));

   param_tcounter #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b0)) u_d1 (
      .clk(clk), .rst(rst), .T(t_i[1]), .up(up_i[1]), .load(ld_i[1]),
      .load_val(lv_i[1]), .clr_ovf(clr_i[1]), .q(q_o[1]),
`ifdef GRAY_OUT_EN
      .q_gray(g_o[1]),
`endif
      .tc(tc_o[1]), .ovf(ovf_o[1]));

   param_tcounter #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b1)) u_d2 (
      .clk(clk), .rst(rst), .T(t_i[2]), .up(up_i[2]), .load(ld_i[2]),
      .load_val(lv_i[2]), .clr_ovf(clr_i[2]), .q(q_o[2]),
`ifdef GRAY_OUT_EN
      .q_gray(g_o[2]),
`endif
      .tc(tc_o[2]), .ovf(ovf_o[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      for (int k = 0; k < 3; k++) begin
         t_i[k] = 1'b0; up_i[k] = 1'b0; ld_i[k] = 1'b0; lv_i[k] = 3'd0; clr_i[k] = 1'b0;
      end
   endtask

   // Drive one cycle of inputs to instance id and queue what it must show.
   task automatic row(input int id, input bit t, input bit u, input bit ld,
                      input logic [2:0] lv, input bit clr,
                      input logic [2:0] eq, input bit etc, input bit eovf);
      exp_t e;
      @(posedge clk);
      #1;
      idle();
      t_i[id] = t; up_i[id] = u; ld_i[id] = ld; lv_i[id] = lv; clr_i[id] = clr;
      e.id = id; e.q = eq; e.tc = etc; e.ovf = eovf;
      sb.push_back(e);
   endtask

   // Monitor: one expectation per cycle, checked away from the clock edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("d%0d_q", e.id),   32'(q_o[e.id]),   32'(e.q));
            chk($sformatf("d%0d_tc", e.id),  32'(tc_o[e.id]),  32'(e.tc));
            chk($sformatf("d%0d_ovf", e.id), 32'(ovf_o[e.id]), 32'(e.ovf));
`ifdef GRAY_OUT_EN
            if (e.id == 0)
               chk("d0_gray", 32'(g_o[0]), 32'(gray_tab[e.q]));
`endif
         end
      end
   end

   initial begin
      int wait_cnt;
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_d%0d_q", k),   32'(q_o[k]),   32'd0);
         chk($sformatf("rst_d%0d_ovf", k), 32'(ovf_o[k]), 32'd0);
      end
      rst = 1'b0;

      // d0: full binary wrap, then async reset while at q=5 with ovf set.
      for (int i = 0; i < 8; i++) row(0, 1, 1, 0, 3'd0, 0, 3'(i), (i == 7), 0);
      for (int i = 0; i < 5; i++) row(0, 1, 1, 0, 3'd0, 0, 3'(i), 0, 1);
      row(0, 0, 0, 0, 3'd0, 0, 3'd5, 0, 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_q",   32'(q_o[0]),   32'd0);
      chk("midrst_ovf", 32'(ovf_o[0]), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 8; i++) row(0, 1, 1, 0, 3'd0, 0, 3'(i), (i == 7), 0);
      row(0, 0, 0, 1, 3'd6, 0, 3'd0, 0, 1);       // load 6 (in range)
      row(0, 1, 0, 0, 3'd0, 0, 3'd6, 0, 1);       // down 6 -> 5
      row(0, 0, 0, 0, 3'd0, 0, 3'd5, 0, 1);

      // d1: modulo-6 wrap up and down, load clamp, ovf priority.
      for (int i = 0; i < 6; i++) row(1, 1, 1, 0, 3'd0, 0, 3'(i), (i == 5), 0);
      row(1, 1, 0, 0, 3'd0, 0, 3'd0, 1, 1);       // 0 -> 5 underflow
      row(1, 1, 0, 0, 3'd0, 0, 3'd5, 0, 1);       // 5 -> 4
      row(1, 0, 0, 1, 3'd2, 0, 3'd4, 0, 1);       // load 2
      row(1, 1, 1, 1, 3'd7, 0, 3'd2, 0, 1);       // load 7 wins, clamped to 5
      repeat (4) row(1, 0, 0, 0, 3'd0, 0, 3'd5, 0, 1);
      row(1, 0, 0, 0, 3'd0, 1, 3'd5, 0, 1);       // clear ovf
      row(1, 1, 1, 0, 3'd0, 1, 3'd5, 1, 0);       // set beats clear
      row(1, 0, 0, 0, 3'd0, 1, 3'd0, 0, 1);       // clear with tc=0
      row(1, 0, 0, 0, 3'd0, 0, 3'd0, 0, 0);

      // d2: saturating modulo-6.
      row(2, 0, 0, 1, 3'd4, 0, 3'd0, 0, 0);
      row(2, 1, 1, 0, 3'd0, 0, 3'd4, 0, 0);
      row(2, 1, 1, 0, 3'd0, 0, 3'd5, 1, 0);
      row(2, 1, 1, 0, 3'd0, 0, 3'd5, 1, 1);
      row(2, 0, 0, 0, 3'd0, 0, 3'd5, 0, 1);
      row(2, 1, 1, 1, 3'd1, 0, 3'd5, 0, 1);       // load masks tc at the top
      row(2, 1, 0, 0, 3'd0, 0, 3'd1, 0, 1);
      row(2, 1, 0, 0, 3'd0, 0, 3'd0, 1, 1);
      row(2, 1, 0, 0, 3'd0, 0, 3'd0, 1, 1);
      row(2, 0, 0, 0, 3'd0, 1, 3'd0, 0, 1);
      row(2, 0, 0, 0, 3'd0, 0, 3'd0, 0, 0);

      @(posedge clk);
      #1 idle();
      wait_cnt = 0;
      while (sb.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      if (sb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain pending=%0d expected=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/param_tcounter.md
Name: param_tcounter

Overview:
Parametrised successor to the team's 3-bit T-enabled binary counter. Generalises width and modulus, adds up/down direction, synchronous load, wrap-or-saturate mode, a terminal-count strobe and a sticky overflow flag. Used as the generic event and cycle counter in datapath and timer blocks. Clocked on `clk`, with an asynchronous active-high reset `rst`.

Parameters:
- WIDTH, 3, counter width in bits (>=1).
- MODULUS, 8, count range 0..MODULUS-1. Constraint: 2 <= MODULUS <= 2**WIDTH.
- SATURATE, 0, 0 = wrap at the range ends; 1 = hold at the range ends.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- T, input, 1, count enable. When 1, advance one step per clock.
- up, input, 1, direction: 1 = increment, 0 = decrement. Sampled only when T=1.
- load, input, 1, synchronous load strobe.
- load_val, input, WIDTH, value to load.
- clr_ovf, input, 1, synchronous clear of ovf.
- q, output, WIDTH, registered count.
- tc, output, 1, terminal-count strobe (combinational).
- ovf, output, 1, sticky overflow/underflow flag (registered).

Behaviour:
- Reset: rst=1 forces q=0 and ovf=0 immediately, without waiting for a clock edge. The reset stays in force while rst is held. The first count happens on the first rising clk edge after rst is released.
- Per-edge update priority (highest first): load, then T, then hold.
- load=1: q <= min(load_val, MODULUS-1). Values out of range are clamped, never stored. T and up are ignored that cycle.
- T=1, load=0, up=1:
  - If q < MODULUS-1: q <= q+1.
  - If q = MODULUS-1: q <= 0 when SATURATE=0; q holds when SATURATE=1.
- T=1, load=0, up=0:
  - If q > 0: q <= q-1.
  - If q = 0: q <= MODULUS-1 when SATURATE=0; q holds when SATURATE=1.
- T=0, load=0: q holds.
- Latency: one clock from T or load to the new q.
- Terminal count:
  - tc = T & ~load & ((up & q==MODULUS-1) | (~up & q==0)).
  - tc is combinational and flags the cycle whose edge will wrap, or attempt to pass the range end when SATURATE=1.
  - tc is asserted for exactly one cycle per wrap when T is held high.
- ovf:
  - Set on any clock edge where tc=1.
  - Cleared on a clock edge where clr_ovf=1 and tc=0.
  - If tc=1 and clr_ovf=1 on the same edge, set wins and ovf=1.
  - load does not affect ovf.
- No internal state exists beyond q and ovf. There are no illegal states, because the clamp keeps q < MODULUS.
- MODULUS = 2**WIDTH must synthesise to a plain binary counter, with no comparator needed for the wrap.

Optional Feature:
GRAY_OUT_EN

- Defined:
  - Adds output port q_gray [WIDTH], registered, equal to q ^ (q >> 1).
  - q_gray updates on the same edge as q.
  - Reset value is 0 (asynchronous, with rst).
  - Used for safe clock-domain-crossing sampling. Only valid when MODULUS = 2**WIDTH; otherwise the wrap from MODULUS-1 to 0 changes more than one bit.
- Undefined:
  - The port and its register are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=3, MODULUS=8, SATURATE=0. Assert rst mid-count at q=5, between clock edges -> q=0 and ovf=0 before the next edge. Release rst with T=1, up=1 -> q reads 1,2,...,7,0. tc=1 only during the q=7 cycle; ovf=1 after the wrap.
- WIDTH=3, MODULUS=6, SATURATE=0, up=1 from 0 -> q reads 0,1,2,3,4,5,0. tc=1 at q=5. Then up=0 from 0 -> q=5, with tc=1 in the q=0 cycle.
- WIDTH=3, MODULUS=6, SATURATE=1. Up from 4 -> q=5 and stays at 5; tc=1 on each cycle with T=1 at 5; ovf=1. Down from 1 -> q=0 and holds; tc=1 while held.
- Load precedence: q=2, T=1, up=1, load=1, load_val=7 with MODULUS=6 -> q=5 next cycle; tc=0 during the load cycle. Then T=0 -> q holds at 5 for 4 cycles.
- ovf priority: ovf=0, q=5 (MODULUS=6), T=1, up=1, clr_ovf=1 on the same edge -> ovf=1. Next edge with clr_ovf=1, tc=0 -> ovf=0.
- GRAY_OUT_EN defined, WIDTH=3, MODULUS=8, count 0..7 -> q_gray reads 000,001,011,010,110,111,101,100,000. Exactly one bit changes per step, including the 7 to 0 wrap.
